// File: rtl/core_task_dispatcher_if.sv
// Handshake bundle between cpu0's control port, the task dispatcher and the worker cores.
interface core_task_dispatcher_if #(
  parameter int unsigned NUM_CORES = 2,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned PC_W      = 16
);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic                 task_valid;
  logic [PC_W-1:0]      task_adr;
  logic                 task_ready;
  logic                 flush;
  logic [NUM_CORES-1:0] core_end;
  logic [NUM_CORES-1:0] core_start;
  logic [PC_W-1:0]      core_start_adr;
  logic [NUM_CORES-1:0] core_busy;
  logic [CNT_W-1:0]     fifo_count;
  logic                 all_idle;

  // Requester / core side: offers tasks, reports task completion
  modport master (
    output task_valid, task_adr, flush, core_end,
    input  task_ready, core_start, core_start_adr, core_busy, fifo_count, all_idle
  );

  // Dispatcher side
  modport slave (
    input  task_valid, task_adr, flush, core_end,
    output task_ready, core_start, core_start_adr, core_busy, fifo_count, all_idle
  );
endinterface

// File: rtl/core_task_dispatcher.sv
// Task dispatcher: queues start PCs from cpu0 in a FIFO and hands each one to an idle
// worker core, chosen round-robin, at most one dispatch per cycle.
module core_task_dispatcher #(
  parameter int unsigned NUM_CORES = 2,
  parameter int unsigned DEPTH     = 4,
  parameter int unsigned PC_W      = 16
) (
  input logic                   clk,
  input logic                   rst,
  core_task_dispatcher_if.slave bus
);
  localparam int unsigned AW = $clog2(DEPTH);
  localparam int unsigned CW = $clog2(DEPTH + 1);
  localparam int unsigned RW = (NUM_CORES > 1) ? $clog2(NUM_CORES) : 1;
  localparam logic [CW-1:0] FULL_CNT  = CW'(DEPTH);
  localparam logic [RW-1:0] LAST_CORE = RW'(NUM_CORES - 1);

  logic [PC_W-1:0]      mem_q [DEPTH];
  logic [AW-1:0]        wr_q, wr_d, rd_q, rd_d;
  logic [CW-1:0]        count_q, count_d;
  logic [RW-1:0]        rr_q, rr_d;
  logic [NUM_CORES-1:0] busy_q, busy_d;
  logic [NUM_CORES-1:0] start_q, start_d;
  logic [PC_W-1:0]      start_adr_q, start_adr_d;

  logic                 ready;
  logic                 push, pop;
  logic                 sel_found;
  logic [RW-1:0]        sel, cand;
  int unsigned          scan;

  // Ready looks only at the registered count, so a full FIFO refuses a push even on a pop cycle
  assign ready = rst && (count_q != FULL_CNT);
  assign push  = bus.task_valid && ready && !bus.flush;
  assign pop   = (count_q != '0) && !bus.flush && sel_found;

  assign bus.task_ready     = ready;
  assign bus.core_start     = start_q;
  assign bus.core_start_adr = start_adr_q;
  assign bus.core_busy      = busy_q;
  assign bus.fifo_count     = count_q;
  assign bus.all_idle       = (count_q == '0) && (busy_q == '0);

  // Pick the first idle core scanning from rr_q; uses registered busy so a core freed this
  // cycle is only eligible from the next one
  always_comb begin
    sel_found = 1'b0;
    sel       = '0;
    cand      = '0;
    scan      = 0;
    for (int unsigned k = 0; k < NUM_CORES; k++) begin
      scan = (32'(rr_q) + k) % NUM_CORES;
      cand = RW'(scan);
      if (!sel_found && !busy_q[cand]) begin
        sel_found = 1'b1;
        sel       = cand;
      end
    end
  end

  // Next-state: pointers, count, busy tracking, round-robin pointer and start pulse
  always_comb begin
    wr_d        = wr_q;
    rd_d        = rd_q;
    count_d     = count_q;
    rr_d        = rr_q;
    busy_d      = busy_q & ~bus.core_end;
    start_d     = '0;
    start_adr_d = '0;
    if (bus.flush) begin
      wr_d    = '0;
      rd_d    = '0;
      count_d = '0;
    end else begin
      if (push) begin
        wr_d = wr_q + 1'b1;
      end
      if (pop) begin
        rd_d         = rd_q + 1'b1;
        start_d[sel] = 1'b1;
        start_adr_d  = mem_q[rd_q];
        busy_d[sel]  = 1'b1;
        rr_d         = (sel == LAST_CORE) ? '0 : sel + 1'b1;
      end
      unique case ({push, pop})
        2'b10:   count_d = count_q + 1'b1;
        2'b01:   count_d = count_q - 1'b1;
        default: count_d = count_q;
      endcase
    end
  end

  // Task storage; contents are don't-care while empty so no reset is needed
  always_ff @(posedge clk) begin
    if (push) begin
      mem_q[wr_q] <= bus.task_adr;
    end
  end

  // State registers with synchronous active-low reset
  always_ff @(posedge clk) begin
    if (!rst) begin
      wr_q        <= '0;
      rd_q        <= '0;
      count_q     <= '0;
      rr_q        <= '0;
      busy_q      <= '0;
      start_q     <= '0;
      start_adr_q <= '0;
    end else begin
      wr_q        <= wr_d;
      rd_q        <= rd_d;
      count_q     <= count_d;
      rr_q        <= rr_d;
      busy_q      <= busy_d;
      start_q     <= start_d;
      start_adr_q <= start_adr_d;
    end
  end
endmodule

// File: tb/tb_core_task_dispatcher.sv
// Directed bench for core_task_dispatcher (2 cores, 4-entry FIFO, 16-bit PCs).
module tb_core_task_dispatcher;
  localparam int unsigned NUM_CORES = 2;
  localparam int unsigned DEPTH     = 4;
  localparam int unsigned PC_W      = 16;

  logic clk;
  logic rst;
  int   total;
  int   bad;

  core_task_dispatcher_if #(.NUM_CORES(NUM_CORES), .DEPTH(DEPTH), .PC_W(PC_W)) bus ();

  core_task_dispatcher #(.NUM_CORES(NUM_CORES), .DEPTH(DEPTH), .PC_W(PC_W)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    assert (got === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
    end
  endtask

  // Checks start pulse, start address, busy and count in one call
  task automatic chk_state(input string tag, input logic [1:0] st, input logic [15:0] adr,
                           input logic [1:0] busy, input logic [2:0] cnt);
    chk({tag, ".start"}, 32'(bus.core_start), 32'(st));
    chk({tag, ".adr"}, 32'(bus.core_start_adr), 32'(adr));
    chk({tag, ".busy"}, 32'(bus.core_busy), 32'(busy));
    chk({tag, ".count"}, 32'(bus.fifo_count), 32'(cnt));
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    tick();
    rst = 1'b1;
    #1;
  endtask

  initial begin
    total = 0;
    bad   = 0;
    rst   = 1'b0;
    bus.task_valid = 1'b0;
    bus.task_adr   = '0;
    bus.flush      = 1'b0;
    bus.core_end   = '0;

    // 1: reset values, then a single task
    tick();
    tick();
    chk_state("rst", 2'b00, 16'h0000, 2'b00, 3'd0);
    chk("rst.ready_low", 32'(bus.task_ready), 32'd0);
    chk("rst.all_idle", 32'(bus.all_idle), 32'd1);
    rst = 1'b1;
    #1;
    chk("rst.ready_high", 32'(bus.task_ready), 32'd1);
    bus.task_valid = 1'b1;
    bus.task_adr   = 16'h0100;
    tick();
    bus.task_valid = 1'b0;
    chk_state("t1.push", 2'b00, 16'h0000, 2'b00, 3'd1);
    tick();
    chk_state("t1.disp", 2'b01, 16'h0100, 2'b01, 3'd0);
    chk("t1.all_idle", 32'(bus.all_idle), 32'd0);
    tick();
    chk_state("t1.after", 2'b00, 16'h0000, 2'b01, 3'd0);

    // 2: three back-to-back pushes with both cores idle
    do_reset();
    bus.task_valid = 1'b1;
    bus.task_adr   = 16'h0010;
    tick();
    chk_state("t2.a", 2'b00, 16'h0000, 2'b00, 3'd1);
    bus.task_adr = 16'h0020;
    tick();
    chk_state("t2.b", 2'b01, 16'h0010, 2'b01, 3'd1);
    bus.task_adr = 16'h0030;
    tick();
    chk_state("t2.c", 2'b10, 16'h0020, 2'b11, 3'd1);
    bus.task_valid = 1'b0;
    tick();
    chk_state("t2.wait", 2'b00, 16'h0000, 2'b11, 3'd1);
    bus.core_end = 2'b01;
    tick();
    bus.core_end = 2'b00;
    chk_state("t2.end", 2'b00, 16'h0000, 2'b10, 3'd1);
    tick();
    chk_state("t2.redisp", 2'b01, 16'h0030, 2'b11, 3'd0);

    // 3: both busy, fill FIFO and hold a fifth task; full refuses push even on a pop cycle
    bus.task_valid = 1'b1;
    bus.task_adr = 16'h00a1; tick();
    bus.task_adr = 16'h00a2; tick();
    bus.task_adr = 16'h00a3; tick();
    chk("t3.ready3", 32'(bus.task_ready), 32'd1);
    bus.task_adr = 16'h00a4; tick();
    chk("t3.ready4", 32'(bus.task_ready), 32'd0);
    chk_state("t3.full", 2'b00, 16'h0000, 2'b11, 3'd4);
    bus.task_adr = 16'h00a5;
    tick();
    chk_state("t3.held", 2'b00, 16'h0000, 2'b11, 3'd4);
    bus.core_end = 2'b01;
    tick();
    bus.core_end = 2'b00;
    chk_state("t3.free1", 2'b00, 16'h0000, 2'b10, 3'd4);
    tick();
    chk_state("t3.popfull", 2'b01, 16'h00a1, 2'b11, 3'd3);
    tick();
    bus.task_valid = 1'b0;
    chk_state("t3.push5", 2'b00, 16'h0000, 2'b11, 3'd4);

    // 4: round-robin; rr points at core2 here
    bus.core_end = 2'b11;
    tick();
    bus.core_end = 2'b00;
    chk_state("t4.free", 2'b00, 16'h0000, 2'b00, 3'd4);
    tick();
    chk_state("t4.rr1a", 2'b10, 16'h00a2, 2'b10, 3'd3);
    tick();
    chk_state("t4.rr1b", 2'b01, 16'h00a3, 2'b11, 3'd2);
    bus.core_end = 2'b10;
    tick();
    bus.core_end = 2'b00;
    tick();
    chk_state("t4.c2", 2'b10, 16'h00a4, 2'b11, 3'd1);
    bus.core_end   = 2'b11;
    bus.task_valid = 1'b1;
    bus.task_adr   = 16'h00a6;
    tick();
    bus.core_end   = 2'b00;
    bus.task_valid = 1'b0;
    chk_state("t4.free2", 2'b00, 16'h0000, 2'b00, 3'd2);
    tick();
    chk_state("t4.rr0a", 2'b01, 16'h00a5, 2'b01, 3'd1);
    tick();
    chk_state("t4.rr0b", 2'b10, 16'h00a6, 2'b11, 3'd0);

    // 5: flush with three queued and a simultaneous push, one core idle
    bus.task_valid = 1'b1;
    bus.task_adr = 16'h00b1; tick();
    bus.task_adr = 16'h00b2; tick();
    bus.task_adr = 16'h00b3; tick();
    bus.task_valid = 1'b0;
    bus.core_end = 2'b01;
    tick();
    bus.core_end = 2'b00;
    chk_state("t5.pre", 2'b00, 16'h0000, 2'b10, 3'd3);
    bus.flush      = 1'b1;
    bus.task_valid = 1'b1;
    bus.task_adr   = 16'h00b4;
    tick();
    bus.flush      = 1'b0;
    bus.task_valid = 1'b0;
    chk_state("t5.flush", 2'b00, 16'h0000, 2'b10, 3'd0);
    tick();
    chk_state("t5.post", 2'b00, 16'h0000, 2'b10, 3'd0);
    chk("t5.all_idle", 32'(bus.all_idle), 32'd0);

    // 6: reset while a start pulse is showing and tasks are queued
    bus.task_valid = 1'b1;
    bus.task_adr = 16'h00c1; tick();
    bus.task_adr = 16'h00c2; tick();
    chk_state("t6.pre", 2'b01, 16'h00c1, 2'b11, 3'd1);
    rst          = 1'b0;
    bus.task_adr = 16'h00c3;
    #1;
    chk("t6.ready_low", 32'(bus.task_ready), 32'd0);
    tick();
    chk_state("t6.rst", 2'b00, 16'h0000, 2'b00, 3'd0);
    chk("t6.all_idle", 32'(bus.all_idle), 32'd1);
    rst            = 1'b1;
    bus.task_valid = 1'b0;
    tick();
    chk_state("t6.lost", 2'b00, 16'h0000, 2'b00, 3'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
